// File: rtl/kick_charge_controller_pkg.sv
// Shared state encoding and default tuning constants for the kick charge controller.
package kick_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHARGE   = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } kick_state_t;

  localparam int DEF_FRAMES_PER_LEVEL = 8;
  localparam int DEF_LEVEL_W          = 3;
  localparam int DEF_MIN_LEVEL        = 1;
  localparam int DEF_MAX_LEVEL        = 7;
  localparam int DEF_COOLDOWN_FRAMES  = 30;
  localparam int DEF_ABORT_FRAMES     = 2;

endpackage

// File: rtl/frame_event_counter.sv
// Frame-gated, clearable, saturating counter; o_terminal is high while the count sits at TERMINAL.
module frame_event_counter #(
  parameter int TERMINAL = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sof,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_terminal
);

  localparam int W = $clog2(TERMINAL) + 1;

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_sof && i_enable && (r_count != W'(TERMINAL))) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_terminal = (r_count == W'(TERMINAL));

endmodule

// File: rtl/kick_charge_controller.sv
// Turns a held kick key into a power level and a one-cycle kick strobe on release, with cooldown.
module kick_charge_controller
  import kick_pkg::*;
#(
  parameter int FRAMES_PER_LEVEL = DEF_FRAMES_PER_LEVEL,
  parameter int LEVEL_W          = DEF_LEVEL_W,
  parameter int MIN_LEVEL        = DEF_MIN_LEVEL,
  parameter int MAX_LEVEL        = DEF_MAX_LEVEL,
  parameter int COOLDOWN_FRAMES  = DEF_COOLDOWN_FRAMES,
  parameter int ABORT_FRAMES     = DEF_ABORT_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               Key_is_pressed,
  input  logic               wasReleased,
  input  logic               ballInReach,
  output logic               kickStrobe,
  output logic [LEVEL_W-1:0] kickPower,
  output logic [LEVEL_W-1:0] chargeLevel,
  output logic               charging,
  output logic               coolingDown
);

  kick_state_t        r_state;
  kick_state_t        w_next;
  logic               r_rel_q;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] r_kick_power;
  logic               r_strobe;
  logic               r_charging;
  logic               r_cooling;

  logic w_rel_rise;
  logic w_enter_charge;
  logic w_frame_hi;
  logic w_frame_lo;
  logic w_level_term;
  logic w_low_term;
  logic w_cd_term;

  assign w_rel_rise     = wasReleased & ~r_rel_q;
  assign w_enter_charge = (r_state == IDLE) & Key_is_pressed;
  // A release event owns its cycle: the coincident frame is neither a hold frame nor a low frame.
  assign w_frame_hi     = (r_state == CHARGE) & startOfFrame & Key_is_pressed & ~w_rel_rise;
  assign w_frame_lo     = (r_state == CHARGE) & startOfFrame & ~Key_is_pressed & ~w_rel_rise;

  frame_event_counter #(.TERMINAL(FRAMES_PER_LEVEL - 1)) u_level_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_sof      (startOfFrame),
    .i_enable   (w_frame_hi),
    .i_clear    (w_enter_charge | (w_frame_hi & w_level_term)),
    .o_terminal (w_level_term)
  );

  // Terminal is one short of the abort count: the next low frame is the one that aborts.
  frame_event_counter #(.TERMINAL(ABORT_FRAMES - 1)) u_abort_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_sof      (startOfFrame),
    .i_enable   (w_frame_lo),
    .i_clear    (w_enter_charge | w_frame_hi),
    .o_terminal (w_low_term)
  );

  frame_event_counter #(.TERMINAL(COOLDOWN_FRAMES)) u_cooldown_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_sof      (startOfFrame),
    .i_enable   (r_state == COOLDOWN),
    .i_clear    (r_state == FIRE),
    .o_terminal (w_cd_term)
  );

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (Key_is_pressed) w_next = CHARGE;
      CHARGE: begin
        if (w_rel_rise)                     w_next = ballInReach ? FIRE : IDLE;
        else if (w_frame_lo && w_low_term)  w_next = IDLE;
      end
      FIRE:     w_next = COOLDOWN;
      COOLDOWN: if (w_cd_term && !Key_is_pressed) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rel_q      <= 1'b0;
      r_level      <= '0;
      r_kick_power <= '0;
      r_strobe     <= 1'b0;
      r_charging   <= 1'b0;
      r_cooling    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rel_q    <= wasReleased;
      r_strobe   <= (w_next == FIRE);
      r_charging <= (w_next == CHARGE);
      r_cooling  <= (w_next == COOLDOWN);

      // Power is captured on the same edge that raises the strobe, so both are valid together.
      if (w_next == FIRE) r_kick_power <= r_level;

      if (w_enter_charge) begin
        r_level <= LEVEL_W'(MIN_LEVEL);
      end else if (w_next != CHARGE) begin
        r_level <= '0;
      end else if (w_frame_hi && w_level_term && (r_level != LEVEL_W'(MAX_LEVEL))) begin
        r_level <= r_level + LEVEL_W'(1);
      end
    end
  end

  assign kickStrobe  = r_strobe;
  assign kickPower   = r_kick_power;
  assign chargeLevel = r_level;
  assign charging    = r_charging;
  assign coolingDown = r_cooling;

endmodule

// File: tb/tb_kick_charge_controller.sv
// Directed bench: table of press/release scenarios plus hand-written corner sequences.
module tb_kick_charge_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       Key_is_pressed;
  logic       wasReleased;
  logic       ballInReach;
  logic       kickStrobe;
  logic [2:0] kickPower;
  logic [2:0] chargeLevel;
  logic       charging;
  logic       coolingDown;

  int n_checks   = 0;
  int n_errors   = 0;
  int strobe_cnt = 0;

  typedef struct {
    int frames;
    bit ball;
    int rel_len;
    int exp_level;
    int exp_strobes;
    int exp_power;
    bit exp_cool;
  } vec_t;

  vec_t vecs[5];

  kick_charge_controller dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .Key_is_pressed (Key_is_pressed),
    .wasReleased    (wasReleased),
    .ballInReach    (ballInReach),
    .kickStrobe     (kickStrobe),
    .kickPower      (kickPower),
    .chargeLevel    (chargeLevel),
    .charging       (charging),
    .coolingDown    (coolingDown)
  );

  always #5 clk = ~clk;

  // Counting on the falling edge counts each clock-wide strobe exactly once.
  always @(negedge clk) if (kickStrobe) strobe_cnt++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic press();
    Key_is_pressed = 1'b1;
    cyc(2);
  endtask

  task automatic release_key(input int len);
    Key_is_pressed = 1'b0;
    wasReleased    = 1'b1;
    cyc(len);
    wasReleased    = 1'b0;
    cyc(3);
  endtask

  task automatic wait_cooldown(input string tag);
    frames(29);
    check({tag, " cooling after 29 frames"}, int'(coolingDown), 1);
    frames(1);
    check({tag, " cooling after 30 frames"}, int'(coolingDown), 0);
  endtask

  initial begin
    vecs[0] = '{frames: 20,  ball: 1'b1, rel_len: 1, exp_level: 3, exp_strobes: 1, exp_power: 3, exp_cool: 1'b1};
    vecs[1] = '{frames: 100, ball: 1'b1, rel_len: 5, exp_level: 7, exp_strobes: 1, exp_power: 7, exp_cool: 1'b1};
    vecs[2] = '{frames: 12,  ball: 1'b0, rel_len: 1, exp_level: 2, exp_strobes: 0, exp_power: 7, exp_cool: 1'b0};
    vecs[3] = '{frames: 0,   ball: 1'b1, rel_len: 5, exp_level: 1, exp_strobes: 1, exp_power: 1, exp_cool: 1'b1};
    vecs[4] = '{frames: 40,  ball: 1'b1, rel_len: 1, exp_level: 6, exp_strobes: 1, exp_power: 6, exp_cool: 1'b1};

    reset          = 1'b1;
    startOfFrame   = 1'b0;
    Key_is_pressed = 1'b0;
    wasReleased    = 1'b0;
    ballInReach    = 1'b0;
    cyc(3);
    check("reset strobe",   int'(kickStrobe),  0);
    check("reset power",    int'(kickPower),   0);
    check("reset level",    int'(chargeLevel), 0);
    check("reset charging", int'(charging),    0);
    check("reset cooling",  int'(coolingDown), 0);
    reset = 1'b0;
    cyc(2);
    check("idle charging", int'(charging), 0);

    for (int i = 0; i < 5; i++) begin
      ballInReach = vecs[i].ball;
      press();
      frames(vecs[i].frames);
      check($sformatf("row%0d level before release", i), int'(chargeLevel), vecs[i].exp_level);
      check($sformatf("row%0d charging", i), int'(charging), 1);
      strobe_cnt = 0;
      release_key(vecs[i].rel_len);
      check($sformatf("row%0d strobes", i), strobe_cnt, vecs[i].exp_strobes);
      check($sformatf("row%0d kick power", i), int'(kickPower), vecs[i].exp_power);
      check($sformatf("row%0d cooling", i), int'(coolingDown), int'(vecs[i].exp_cool));
      check($sformatf("row%0d charging after", i), int'(charging), 0);
      check($sformatf("row%0d level after", i), int'(chargeLevel), 0);
      if (vecs[i].exp_cool) wait_cooldown($sformatf("row%0d", i));
    end

    // Release rising together with a frame while the key still reads held: the frame must not count.
    ballInReach = 1'b1;
    press();
    frames(7);
    check("coincident level before", int'(chargeLevel), 1);
    strobe_cnt   = 0;
    wasReleased  = 1'b1;
    startOfFrame = 1'b1;
    cyc(1);
    startOfFrame   = 1'b0;
    wasReleased    = 1'b0;
    Key_is_pressed = 1'b0;
    cyc(3);
    check("coincident strobes", strobe_cnt, 1);
    check("coincident power",   int'(kickPower), 1);
    wait_cooldown("coincident");

    // Key held straight through cooldown, then an early-abort charge.
    press();
    frames(20);
    strobe_cnt  = 0;
    wasReleased = 1'b1;
    cyc(1);
    wasReleased = 1'b0;
    cyc(3);
    check("held strobes", strobe_cnt, 1);
    check("held power",   int'(kickPower), 3);
    frames(35);
    check("held cooling",  int'(coolingDown), 1);
    check("held charging", int'(charging),    0);
    check("held level",    int'(chargeLevel), 0);
    Key_is_pressed = 1'b0;
    cyc(2);
    check("held exit cooling", int'(coolingDown), 0);
    press();
    check("recharge charging", int'(charging),    1);
    check("recharge level",    int'(chargeLevel), 1);
    strobe_cnt     = 0;
    Key_is_pressed = 1'b0;
    frames(1);
    check("abort after 1 frame", int'(charging), 1);
    frames(1);
    check("abort after 2 frames", int'(charging),    0);
    check("abort level",          int'(chargeLevel), 0);
    check("abort strobes",        strobe_cnt,        0);

    // Asynchronous reset in the middle of a charge.
    press();
    frames(10);
    check("pre-reset level", int'(chargeLevel), 2);
    #2 reset = 1'b1;
    #1;
    check("async reset charging", int'(charging),    0);
    check("async reset level",    int'(chargeLevel), 0);
    check("async reset power",    int'(kickPower),   0);
    cyc(1);
    reset          = 1'b0;
    Key_is_pressed = 1'b0;
    strobe_cnt     = 0;
    wasReleased    = 1'b1;
    cyc(2);
    wasReleased = 1'b0;
    cyc(3);
    check("post-reset strobes",  strobe_cnt,        0);
    check("post-reset charging", int'(charging),    0);
    check("post-reset power",    int'(kickPower),   0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
